// File: rtl/cube_face_plotter.sv
// Cube face plotter: snapshots six 3x3 cube faces and rasterises them as an unfolded
// cross net, one pixel per clock. Optional pre-blank of the net box: CUBE_PLOT_CLEAR_EN.
module cube_face_plotter #(
    parameter int unsigned CELL = 8,
    parameter int unsigned GAP  = 1,
    parameter int unsigned X0   = 32,
    parameter int unsigned Y0   = 24
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] f1 [0:8],
    input  logic [2:0] f2 [0:8],
    input  logic [2:0] f3 [0:8],
    input  logic [2:0] f4 [0:8],
    input  logic [2:0] f5 [0:8],
    input  logic [2:0] f6 [0:8],
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam int unsigned CW    = 3;
    localparam int unsigned NFACE = 6;
    localparam int unsigned NSTK  = 9;
`ifdef CUBE_PLOT_CLEAR_EN
    localparam int unsigned BOX_W = 12 * CELL;
    localparam int unsigned BOX_H = 9 * CELL;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CLEAR, S_DRAW, S_DONE} state_t;

    state_t        r_state, w_state_next;
    logic [2:0]    r_snap [0:NFACE-1][0:NSTK-1];
    logic [CW-1:0] r_px, r_py, w_px_next, w_py_next;
    logic [3:0]    r_idx, w_idx_next;
    logic [2:0]    r_face, w_face_next;
`ifdef CUBE_PLOT_CLEAR_EN
    logic [7:0]    r_cx, w_cx_next;
    logic [6:0]    r_cy, w_cy_next;
`endif
    logic [7:0]    r_x, w_x_d;
    logic [6:0]    r_y, w_y_d;
    logic [2:0]    r_colour, w_colour_d;
    logic          r_plot, w_plot_d;
    logic          r_busy, w_busy_d;
    logic          r_done, w_done_d;

    int unsigned   w_fcol, w_frow;
    logic [1:0]    w_scol, w_srow;
    logic [7:0]    w_sx;
    logic [6:0]    w_sy;
    logic [2:0]    w_scolour;
    logic          w_gap;
    logic          w_px_last, w_py_last, w_idx_last, w_face_last;

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

    // Net position of each face in draw order: top, left, front, right, back, bottom.
    always_comb begin
        w_fcol = 3;
        w_frow = 0;
        case (r_face)
            3'd1:    begin w_fcol = 0; w_frow = 3; end
            3'd2:    begin w_fcol = 3; w_frow = 3; end
            3'd3:    begin w_fcol = 6; w_frow = 3; end
            3'd4:    begin w_fcol = 9; w_frow = 3; end
            3'd5:    begin w_fcol = 3; w_frow = 6; end
            default: begin w_fcol = 3; w_frow = 0; end
        endcase
    end

    assign w_scol    = 2'(r_idx % 4'd3);
    assign w_srow    = 2'(r_idx / 4'd3);
    assign w_sx      = 8'(X0 + (w_fcol + 32'(w_scol)) * CELL + 32'(r_px));
    assign w_sy      = 7'(Y0 + (w_frow + 32'(w_srow)) * CELL + 32'(r_py));
    assign w_gap     = (32'(r_px) >= CELL - GAP) || (32'(r_py) >= CELL - GAP);
    assign w_scolour = w_gap ? 3'd0 : r_snap[r_face][r_idx];

    assign w_px_last   = (r_px == CW'(CELL - 1));
    assign w_py_last   = (r_py == CW'(CELL - 1));
    assign w_idx_last  = (r_idx == 4'd8);
    assign w_face_last = (r_face == 3'd5);

    // Next-state, counter and output-register logic.
    always_comb begin
        w_state_next = r_state;
        w_px_next    = r_px;
        w_py_next    = r_py;
        w_idx_next   = r_idx;
        w_face_next  = r_face;
`ifdef CUBE_PLOT_CLEAR_EN
        w_cx_next    = r_cx;
        w_cy_next    = r_cy;
`endif
        w_x_d        = r_x;
        w_y_d        = r_y;
        w_colour_d   = r_colour;
        w_plot_d     = 1'b0;
        w_done_d     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_LATCH;
            end
            S_LATCH: begin
                w_px_next   = '0;
                w_py_next   = '0;
                w_idx_next  = '0;
                w_face_next = '0;
`ifdef CUBE_PLOT_CLEAR_EN
                w_cx_next    = '0;
                w_cy_next    = '0;
                w_state_next = S_CLEAR;
`else
                w_state_next = S_DRAW;
`endif
            end
`ifdef CUBE_PLOT_CLEAR_EN
            S_CLEAR: begin
                w_plot_d   = 1'b1;
                w_x_d      = 8'(X0 + 32'(r_cx));
                w_y_d      = 7'(Y0 + 32'(r_cy));
                w_colour_d = 3'd0;
                if (r_cx == 8'(BOX_W - 1)) begin
                    w_cx_next = '0;
                    if (r_cy == 7'(BOX_H - 1)) begin
                        w_cy_next    = '0;
                        w_state_next = S_DRAW;
                    end else begin
                        w_cy_next = r_cy + 7'd1;
                    end
                end else begin
                    w_cx_next = r_cx + 8'd1;
                end
            end
`endif
            S_DRAW: begin
                w_plot_d   = 1'b1;
                w_x_d      = w_sx;
                w_y_d      = w_sy;
                w_colour_d = w_scolour;
                if (w_px_last) begin
                    w_px_next = '0;
                    if (w_py_last) begin
                        w_py_next = '0;
                        if (w_idx_last) begin
                            w_idx_next = '0;
                            if (w_face_last) begin
                                w_face_next  = '0;
                                w_state_next = S_DONE;
                            end else begin
                                w_face_next = r_face + 3'd1;
                            end
                        end else begin
                            w_idx_next = r_idx + 4'd1;
                        end
                    end else begin
                        w_py_next = r_py + CW'(1);
                    end
                end else begin
                    w_px_next = r_px + CW'(1);
                end
            end
            S_DONE: begin
                w_done_d     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // busy covers LATCH through DONE and drops together with the done pulse.
    assign w_busy_d = (w_state_next != S_IDLE);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_px     <= '0;
            r_py     <= '0;
            r_idx    <= '0;
            r_face   <= '0;
`ifdef CUBE_PLOT_CLEAR_EN
            r_cx     <= '0;
            r_cy     <= '0;
`endif
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_px     <= w_px_next;
            r_py     <= w_py_next;
            r_idx    <= w_idx_next;
            r_face   <= w_face_next;
`ifdef CUBE_PLOT_CLEAR_EN
            r_cx     <= w_cx_next;
            r_cy     <= w_cy_next;
`endif
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_colour <= w_colour_d;
            r_plot   <= w_plot_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
        end
    end

    // Snapshot stored in draw order so the face counter indexes it directly.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NFACE); i++)
                for (int j = 0; j < int'(NSTK); j++)
                    r_snap[i][j] <= '0;
        end else if (r_state == S_LATCH) begin
            for (int j = 0; j < int'(NSTK); j++) begin
                r_snap[0][j] <= f5[j];
                r_snap[1][j] <= f3[j];
                r_snap[2][j] <= f1[j];
                r_snap[3][j] <= f4[j];
                r_snap[4][j] <= f2[j];
                r_snap[5][j] <= f6[j];
            end
        end
    end

endmodule

// File: tb/tb_cube_face_plotter.sv
// Directed self-checking bench for cube_face_plotter (default geometry CELL=8, GAP=1, X0=32, Y0=24).
module tb_cube_face_plotter;
    localparam int FL_STK = 3456;
`ifdef CUBE_PLOT_CLEAR_EN
    localparam int FL_CLR = 6912;
`else
    localparam int FL_CLR = 0;
`endif
    localparam int FL     = FL_STK + FL_CLR;
    localparam int BUDGET = FL + 50;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic [2:0] f1 [0:8];
    logic [2:0] f2 [0:8];
    logic [2:0] f3 [0:8];
    logic [2:0] f4 [0:8];
    logic [2:0] f5 [0:8];
    logic [2:0] f6 [0:8];
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Statistics of the most recent run_frame call.
    int n_plot, n_done, first_i, last_i, done_i, n4, n7;
    int first_x, first_y, first_c, last_x, last_y, last_c;
    int min_x, max_x, min_y, max_y;
    logic busy0, plot0, busy_at_done;
    int pix [0:159][0:119];

    cube_face_plotter dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .f1(f1), .f2(f2), .f3(f3), .f4(f4), .f5(f5), .f6(f6),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic set_all(input logic [2:0] v);
        for (int j = 0; j < 9; j++) begin
            f1[j] = v; f2[j] = v; f3[j] = v; f4[j] = v; f5[j] = v; f6[j] = v;
        end
    endtask

    // Pulses start for one cycle and records every plot until done (bounded).
    task automatic run_frame(input int change_at, input int pulse_at);
        n_plot = 0; n_done = 0; first_i = -1; last_i = -1; done_i = -1; n4 = 0; n7 = 0;
        first_x = -1; first_y = -1; first_c = -1; last_x = -1; last_y = -1; last_c = -1;
        min_x = 999; max_x = -1; min_y = 999; max_y = -1; busy_at_done = 1'b1;
        for (int a = 0; a < 160; a++)
            for (int b = 0; b < 120; b++)
                pix[a][b] = -1;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        busy0 = busy;
        plot0 = plot;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge CLOCK_50);
            if (plot) begin
                n_plot++;
                if (first_i < 0) begin
                    first_i = i; first_x = int'(x); first_y = int'(y); first_c = int'(colour);
                end
                last_i = i; last_x = int'(x); last_y = int'(y); last_c = int'(colour);
                if (colour == 3'd4) n4++;
                if (colour == 3'd7) n7++;
                if (int'(x) < min_x) min_x = int'(x);
                if (int'(x) > max_x) max_x = int'(x);
                if (int'(y) < min_y) min_y = int'(y);
                if (int'(y) > max_y) max_y = int'(y);
                if (int'(x) < 160 && int'(y) < 120) pix[int'(x)][int'(y)] = int'(colour);
            end
            if (done) begin
                n_done++;
                if (done_i < 0) begin done_i = i; busy_at_done = busy; end
            end
            start = (i == pulse_at);
            if (i == change_at) set_all(3'd7);
            if (done_i >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_all(3'd0);
        repeat (3) @(negedge CLOCK_50);
        n_cmp++; if (x !== 8'd0)      begin n_fail++; $display("FAIL reset_x got %0d want 0", x); end
        n_cmp++; if (y !== 7'd0)      begin n_fail++; $display("FAIL reset_y got %0d want 0", y); end
        n_cmp++; if (colour !== 3'd0) begin n_fail++; $display("FAIL reset_colour got %0d want 0", colour); end
        n_cmp++; if (plot !== 1'b0)   begin n_fail++; $display("FAIL reset_plot got %b want 0", plot); end
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_uniform();
        int exp_fx, exp_fc;
        exp_fx = (FL_CLR > 0) ? 32 : 56;
        exp_fc = (FL_CLR > 0) ? 0 : 1;
        set_all(3'd1);
        run_frame(-1, -1);
        n_cmp++; if (plot0 !== 1'b0)   begin n_fail++; $display("FAIL uni_latch_plot got %b want 0", plot0); end
        n_cmp++; if (busy0 !== 1'b1)   begin n_fail++; $display("FAIL uni_latch_busy got %b want 1", busy0); end
        n_cmp++; if (n_plot !== FL)    begin n_fail++; $display("FAIL uni_count got %0d want %0d", n_plot, FL); end
        n_cmp++; if (first_i !== 2)    begin n_fail++; $display("FAIL uni_first_cycle got %0d want 2", first_i); end
        n_cmp++; if (first_x !== exp_fx) begin n_fail++; $display("FAIL uni_first_x got %0d want %0d", first_x, exp_fx); end
        n_cmp++; if (first_y !== 24)   begin n_fail++; $display("FAIL uni_first_y got %0d want 24", first_y); end
        n_cmp++; if (first_c !== exp_fc) begin n_fail++; $display("FAIL uni_first_c got %0d want %0d", first_c, exp_fc); end
        n_cmp++; if (last_i !== FL + 1) begin n_fail++; $display("FAIL uni_last_cycle got %0d want %0d", last_i, FL + 1); end
        n_cmp++; if (last_x !== 79)    begin n_fail++; $display("FAIL uni_last_x got %0d want 79", last_x); end
        n_cmp++; if (last_y !== 95)    begin n_fail++; $display("FAIL uni_last_y got %0d want 95", last_y); end
        n_cmp++; if (last_c !== 0)     begin n_fail++; $display("FAIL uni_last_c got %0d want 0", last_c); end
        n_cmp++; if (done_i !== FL + 2) begin n_fail++; $display("FAIL uni_done_cycle got %0d want %0d", done_i, FL + 2); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL uni_busy_at_done got %b want 0", busy_at_done); end
        n_cmp++; if (pix[60][28] !== 1) begin n_fail++; $display("FAIL uni_pix_60_28 got %0d want 1", pix[60][28]); end
        @(negedge CLOCK_50);
        n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL uni_done_width got %b want 0", done); end
    endtask

    task automatic test_center_sticker();
        int exp_corner;
        exp_corner = (FL_CLR > 0) ? 0 : -1;
        set_all(3'd0);
        f1[4] = 3'd4;
        run_frame(-1, -1);
        n_cmp++; if (pix[64][56] !== 4) begin n_fail++; $display("FAIL ctr_64_56 got %0d want 4", pix[64][56]); end
        n_cmp++; if (pix[70][62] !== 4) begin n_fail++; $display("FAIL ctr_70_62 got %0d want 4", pix[70][62]); end
        n_cmp++; if (pix[71][60] !== 0) begin n_fail++; $display("FAIL ctr_gap_x71 got %0d want 0", pix[71][60]); end
        n_cmp++; if (pix[66][63] !== 0) begin n_fail++; $display("FAIL ctr_gap_y63 got %0d want 0", pix[66][63]); end
        n_cmp++; if (pix[63][56] !== 0) begin n_fail++; $display("FAIL ctr_left_nb got %0d want 0", pix[63][56]); end
        n_cmp++; if (n4 !== 49)         begin n_fail++; $display("FAIL ctr_count4 got %0d want 49", n4); end
        n_cmp++; if (min_x !== 32)      begin n_fail++; $display("FAIL ctr_min_x got %0d want 32", min_x); end
        n_cmp++; if (max_x !== 127)     begin n_fail++; $display("FAIL ctr_max_x got %0d want 127", max_x); end
        n_cmp++; if (min_y !== 24)      begin n_fail++; $display("FAIL ctr_min_y got %0d want 24", min_y); end
        n_cmp++; if (max_y !== 95)      begin n_fail++; $display("FAIL ctr_max_y got %0d want 95", max_y); end
        n_cmp++; if (pix[32][24] !== exp_corner) begin n_fail++; $display("FAIL ctr_corner got %0d want %0d", pix[32][24], exp_corner); end
    endtask

    task automatic test_snapshot();
        int n_extra;
        set_all(3'd2);
        run_frame(FL_CLR + 1000, FL_CLR + 500);
        n_cmp++; if (n7 !== 0)          begin n_fail++; $display("FAIL snap_no7 got %0d want 0", n7); end
        n_cmp++; if (n_plot !== FL)     begin n_fail++; $display("FAIL snap_count got %0d want %0d", n_plot, FL); end
        n_cmp++; if (pix[64][80] !== 2) begin n_fail++; $display("FAIL snap_bottom got %0d want 2", pix[64][80]); end
        n_cmp++; if (done_i !== FL + 2) begin n_fail++; $display("FAIL snap_done got %0d want %0d", done_i, FL + 2); end
        n_extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (plot || busy) n_extra++;
        end
        n_cmp++; if (n_extra !== 0)     begin n_fail++; $display("FAIL snap_not_queued got %0d want 0", n_extra); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, p1, p2, np, n_low;
        d1 = -1; d2 = -1; p1 = -1; p2 = -1; np = 0; n_low = 0;
        set_all(3'd5);
        start = 1'b1;
        @(negedge CLOCK_50);
        for (int i = 1; i <= 2 * FL + 40; i++) begin
            @(negedge CLOCK_50);
            if (plot) begin
                np++;
                if (p1 < 0) p1 = i;
                if (d1 >= 0 && p2 < 0) p2 = i;
            end
            if (done) begin
                if (d1 < 0) d1 = i;
                else d2 = i;
            end
            if (!busy && d2 < 0) n_low++;
            if (d2 >= 0) begin start = 1'b0; break; end
        end
        start = 1'b0;
        n_cmp++; if (p1 !== 2)          begin n_fail++; $display("FAIL b2b_p1 got %0d want 2", p1); end
        n_cmp++; if (d1 !== FL + 2)     begin n_fail++; $display("FAIL b2b_d1 got %0d want %0d", d1, FL + 2); end
        n_cmp++; if (p2 !== FL + 5)     begin n_fail++; $display("FAIL b2b_p2 got %0d want %0d", p2, FL + 5); end
        n_cmp++; if (d2 !== 2 * FL + 5) begin n_fail++; $display("FAIL b2b_d2 got %0d want %0d", d2, 2 * FL + 5); end
        n_cmp++; if (np !== 2 * FL)     begin n_fail++; $display("FAIL b2b_plots got %0d want %0d", np, 2 * FL); end
        n_cmp++; if (n_low !== 1)       begin n_fail++; $display("FAIL b2b_idle got %0d want 1", n_low); end
        @(negedge CLOCK_50);
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL b2b_stop got %b want 0", busy); end
    endtask

    task automatic test_reset_midframe();
        int np, n_after, exp_fc;
        exp_fc = (FL_CLR > 0) ? 0 : 6;
        np = 0;
        set_all(3'd6);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        for (int i = 0; i < BUDGET && np < 1000; i++) begin
            @(negedge CLOCK_50);
            if (plot) np++;
        end
        n_cmp++; if (np !== 1000)   begin n_fail++; $display("FAIL rst_reach got %0d want 1000", np); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (plot !== 1'b0) begin n_fail++; $display("FAIL rst_plot got %b want 0", plot); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        #9;
        resetn = 1'b1;
        n_after = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (plot || done || busy) n_after++;
        end
        n_cmp++; if (n_after !== 0) begin n_fail++; $display("FAIL rst_quiet got %0d want 0", n_after); end
        run_frame(-1, -1);
        n_cmp++; if (n_plot !== FL)     begin n_fail++; $display("FAIL rst_redraw got %0d want %0d", n_plot, FL); end
        n_cmp++; if (n_done !== 1)      begin n_fail++; $display("FAIL rst_done got %0d want 1", n_done); end
        n_cmp++; if (first_c !== exp_fc) begin n_fail++; $display("FAIL rst_first_c got %0d want %0d", first_c, exp_fc); end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_center_sticker();
        test_snapshot();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
